// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the execute-stage ALU.
//   - OP_* localparams: 4-bit Operation codes, shared with the ALU controller.
//   - alu_op_e: enum view of the same codes.
//   - alu_state_e: execute-unit FSM states.
//   - is_shift(): true for SLL/SRL/SRA.
package alu_pkg;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLL = 4'b0100;
  localparam logic [3:0] OP_SRL = 4'b0101;
  localparam logic [3:0] OP_SRA = 4'b0111;
  localparam logic [3:0] OP_EQ  = 4'b1000;
  localparam logic [3:0] OP_NE  = 4'b1110;
  localparam logic [3:0] OP_SLT = 4'b1100;

  typedef enum logic [3:0] {
    ALU_AND = OP_AND,
    ALU_OR  = OP_OR,
    ALU_ADD = OP_ADD,
    ALU_SUB = OP_SUB,
    ALU_SLL = OP_SLL,
    ALU_SRL = OP_SRL,
    ALU_SRA = OP_SRA,
    ALU_EQ  = OP_EQ,
    ALU_NE  = OP_NE,
    ALU_SLT = OP_SLT
  } alu_op_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } alu_state_e;

  function automatic logic is_shift(input logic [3:0] op);
    return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
  endfunction

endpackage

// File: rtl/alu_exec_unit_serial_shifter.sv
// serial_shifter: one-bit-per-cycle shifter used for SLL/SRL/SRA.
// Ports:
//   clk, reset       clock, async active-high reset
//   load             capture data_in/shamt/shift_left/arith
//   shift_left       1 = SLL, 0 = right shift
//   arith            right shifts fill with the sign bit
//   data_in, shamt   operand and shift amount
//   busy             shifts still outstanding (counter != 0)
//   done             the shift happening this cycle is the last one
//   result           final value: the post-shift value when done, else the
//                    held register once the counter has expired
// Not built when ALU_BARREL_SHIFT_EN is defined.
module serial_shifter #(
  parameter int DATA_WIDTH = 32,
  parameter int SHAMT_W    = $clog2(DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic                  shift_left,
  input  logic                  arith,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [SHAMT_W-1:0]    shamt,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] result
);

  logic [DATA_WIDTH-1:0] work;
  logic [DATA_WIDTH-1:0] work_next;
  logic [SHAMT_W-1:0]    cnt;
  logic                  left_q;
  logic                  arith_q;

  assign work_next = left_q ? {work[DATA_WIDTH-2:0], 1'b0}
                            : {arith_q & work[DATA_WIDTH-1], work[DATA_WIDTH-1:1]};

  assign busy = (cnt != '0);
  assign done = (cnt == SHAMT_W'(1));
  // Exposing the post-shift value on the last count lets the owner write its
  // output register on the same edge the counter expires.
  assign result = busy ? work_next : work;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      work    <= '0;
      cnt     <= '0;
      left_q  <= 1'b0;
      arith_q <= 1'b0;
    end else if (load) begin
      work    <= data_in;
      cnt     <= shamt;
      left_q  <= shift_left;
      arith_q <= arith;
    end else if (busy) begin
      work <= work_next;
      cnt  <= cnt - SHAMT_W'(1);
    end
  end

endmodule

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: execute-stage ALU with valid/ready on both sides.
// Logic, add/sub, compare and unknown ops finish in one cycle; shifts use
// the iterative serial_shifter unless ALU_BARREL_SHIFT_EN is defined, in
// which case shifts are combinational and single-cycle.
// Ports:
//   clk, reset                 clock, async active-high reset
//   in_valid/in_ready          request handshake (in_ready is combinational)
//   in_op, in_a, in_b          Operation code and operands (in_b[SHAMT_W-1:0]
//                              is the shift amount)
//   out_valid/out_ready        result handshake
//   out_result, out_zero       registered result and result==0 flag
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | ready for a request when the output slot is free
// ST_SHIFT | serial shift in progress or finished and waiting for slot
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter  int DATA_WIDTH = 32,
  localparam int SHAMT_W    = $clog2(DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [3:0]            in_op,
  input  logic [DATA_WIDTH-1:0] in_a,
  input  logic [DATA_WIDTH-1:0] in_b,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_result,
  output logic                  out_zero
);

  alu_state_e            state;
  logic                  slot_free;
  logic                  accept;
  logic                  go_shift;
  logic [SHAMT_W-1:0]    shamt;
  logic [DATA_WIDTH-1:0] comb_res;

  assign shamt     = in_b[SHAMT_W-1:0];
  assign slot_free = !out_valid || out_ready;
  assign in_ready  = (state == ST_IDLE) && slot_free;
  assign accept    = in_valid && in_ready;

  always_comb begin
    comb_res = '0;
    case (in_op)
      OP_AND: comb_res = in_a & in_b;
      OP_OR:  comb_res = in_a | in_b;
      OP_ADD: comb_res = in_a + in_b;
      OP_SUB: comb_res = in_a - in_b;
`ifdef ALU_BARREL_SHIFT_EN
      OP_SLL: comb_res = in_a << shamt;
      OP_SRL: comb_res = in_a >> shamt;
      OP_SRA: comb_res = DATA_WIDTH'($signed(in_a) >>> shamt);
`else
      // Only a zero shift amount reaches the single-cycle path.
      OP_SLL, OP_SRL, OP_SRA: comb_res = in_a;
`endif
      OP_EQ:  comb_res = {{(DATA_WIDTH-1){1'b0}}, in_a == in_b};
      OP_NE:  comb_res = {{(DATA_WIDTH-1){1'b0}}, in_a != in_b};
      OP_SLT: comb_res = {{(DATA_WIDTH-1){1'b0}}, $signed(in_a) < $signed(in_b)};
      default: comb_res = '0;
    endcase
  end

`ifdef ALU_BARREL_SHIFT_EN
  assign go_shift = 1'b0;
`else
  logic                  sh_busy;
  logic                  sh_done;
  logic [DATA_WIDTH-1:0] sh_result;

  assign go_shift = accept && is_shift(in_op) && (shamt != '0);

  serial_shifter #(
    .DATA_WIDTH (DATA_WIDTH),
    .SHAMT_W    (SHAMT_W)
  ) u_shifter (
    .clk        (clk),
    .reset      (reset),
    .load       (go_shift),
    .shift_left (in_op == OP_SLL),
    .arith      (in_op == OP_SRA),
    .data_in    (in_a),
    .shamt      (shamt),
    .busy       (sh_busy),
    .done       (sh_done),
    .result     (sh_result)
  );
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      out_valid  <= 1'b0;
      out_result <= '0;
      out_zero   <= 1'b1;
    end else begin
      if (out_valid && out_ready) out_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            if (go_shift) begin
              state <= ST_SHIFT;
            end else begin
              out_result <= comb_res;
              out_zero   <= (comb_res == '0);
              out_valid  <= 1'b1;
            end
          end
        end
`ifndef ALU_BARREL_SHIFT_EN
        ST_SHIFT: begin
          // Finish on the last shift, or later once the slot frees up.
          if ((sh_done || !sh_busy) && slot_free) begin
            out_result <= sh_result;
            out_zero   <= (sh_result == '0);
            out_valid  <= 1'b1;
            state      <= ST_IDLE;
          end
        end
`endif
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
module tb_alu_exec_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_op;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        out_zero;

  int passed = 0;
  int total  = 0;

  alu_exec_unit #(.DATA_WIDTH(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_a       (in_a),
    .in_b       (in_b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_zero   (out_zero)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs === exp) passed++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  // Reference: result straight from the op definitions.
  function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [4:0] sh;
    sh = b[4:0];
    case (op)
      4'b0000: return a & b;
      4'b0001: return a | b;
      4'b0010: return a + b;
      4'b0110: return a - b;
      4'b0100: return a << sh;
      4'b0101: return a >> sh;
      4'b0111: return $signed(a) >>> sh;
      4'b1000: return {31'b0, a == b};
      4'b1110: return {31'b0, a != b};
      4'b1100: return {31'b0, $signed(a) < $signed(b)};
      default: return 32'd0;
    endcase
  endfunction

  // Cycles between acceptance edge and the edge that raises out_valid.
  function automatic int ref_lat(input logic [3:0] op, input logic [31:0] b);
`ifdef ALU_BARREL_SHIFT_EN
    return 0;
`else
    if (op == 4'b0100 || op == 4'b0101 || op == 4'b0111) return int'(b[4:0]);
    return 0;
`endif
  endfunction

  task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int lat, input int stall);
    int n;
    in_op = op; in_a = a; in_b = b; in_valid = 1'b1; out_ready = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin step(); n++; end
    check({tag, "_rdy"}, 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    in_op = 4'($urandom); in_a = $urandom; in_b = $urandom;
    out_ready = (stall == 0);
    n = 0;
    while (!out_valid && n < 40) begin
      check({tag, "_busy"}, 32'(in_ready), 32'd0);
      step();
      n++;
    end
    check({tag, "_lat"}, 32'(n), 32'(lat));
    check({tag, "_res"}, out_result, exp);
    check({tag, "_zero"}, 32'(out_zero), 32'(exp == 32'd0));
    for (int i = 0; i < stall; i++) begin
      step();
      check({tag, "_hold"}, out_result, exp);
      check({tag, "_hold_rdy"}, 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    step();
    check({tag, "_drain"}, 32'(out_valid), 32'd0);
  endtask

  logic [3:0] op_tab [12] = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0100, 4'b0101,
                              4'b0111, 4'b1000, 4'b1110, 4'b1100, 4'b1111, 4'b0011};

  initial begin
    int hits;
    logic [3:0]  op;
    logic [31:0] a, b;

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_op = '0; in_a = '0; in_b = '0;
    step(); step();
    reset = 1'b0;
    #1;
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_zero", 32'(out_zero), 32'd1);
    check("rst_result", out_result, 32'd0);
    check("rst_ready", 32'(in_ready), 32'd1);

    run_op("add_wrap", 4'b0010, 32'hFFFF_FFFF, 32'd1, 32'd0, 0, 0);
    run_op("sra4", 4'b0111, 32'h8000_0000, 32'd4, 32'hF800_0000, ref_lat(4'b0111, 32'd4), 0);
    run_op("srl4", 4'b0101, 32'h8000_0000, 32'd4, 32'h0800_0000, ref_lat(4'b0101, 32'd4), 0);
    run_op("undef", 4'b1111, 32'h1234_5678, 32'h9ABC_DEF0, 32'd0, 0, 0);
    run_op("sll31", 4'b0100, 32'd1, 32'd31, 32'h8000_0000, ref_lat(4'b0100, 32'd31), 1);

    // Back-to-back single-cycle ops.
    out_ready = 1'b1;
    in_valid = 1'b1; in_op = 4'b0110; in_a = 32'd5; in_b = 32'd7;
    step();
    check("b2b_sub", out_result, 32'hFFFF_FFFE);
    in_op = 4'b1100; in_a = 32'hFFFF_FFFE; in_b = 32'd1;
    step();
    check("b2b_slt", out_result, 32'd1);
    in_op = 4'b1110; in_a = 32'd3; in_b = 32'd3;
    step();
    check("b2b_ne", out_result, 32'd0);
    check("b2b_ne_zero", 32'(out_zero), 32'd1);
    in_valid = 1'b0;
    step();
    check("b2b_drain", 32'(out_valid), 32'd0);

    // Backpressure with a pending request released in the same edge.
    out_ready = 1'b0;
    in_valid = 1'b1; in_op = 4'b0010; in_a = 32'd2; in_b = 32'd3;
    step();
    in_op = 4'b0001; in_a = 32'h0000_00F0; in_b = 32'h0000_000F;
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", 32'(out_valid), 32'd1);
      check("bp_result", out_result, 32'd5);
      check("bp_ready", 32'(in_ready), 32'd0);
      step();
    end
    out_ready = 1'b1;
    #1;
    check("bp_release_rdy", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    check("bp_or_valid", 32'(out_valid), 32'd1);
    check("bp_or_result", out_result, 32'h0000_00FF);
    step();
    check("bp_drain", 32'(out_valid), 32'd0);

    // Reset in the middle of a long shift.
    in_valid = 1'b1; in_op = 4'b0100; in_a = 32'd1; in_b = 32'd20;
    step();
    in_valid = 1'b0;
    step(); step();
    reset = 1'b1;
    #1;
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_zero", 32'(out_zero), 32'd1);
    step();
    reset = 1'b0;
    #1;
    check("mid_rst_ready", 32'(in_ready), 32'd1);
    hits = 0;
    for (int i = 0; i < 25; i++) begin
      if (out_valid || !in_ready) hits++;
      step();
    end
    check("mid_rst_quiet", 32'(hits), 32'd0);
    run_op("sll0", 4'b0100, 32'd1, 32'd0, 32'd1, 0, 0);

    // Randomized ops against the reference model.
    for (int t = 0; t < 200; t++) begin
      op = op_tab[$urandom_range(0, 11)];
      a = $urandom;
      b = $urandom;
      if ($urandom_range(0, 3) == 0) b = a;
      if ($urandom_range(0, 3) == 0) a = $urandom_range(0, 3);
      run_op("rnd", op, a, b, ref_alu(op, a, b), ref_lat(op, b), $urandom_range(0, 2));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
